// File: rtl/spi_ram_ctrl_if.sv
// Parallel word bus between the SPI slave and the command-decoding RAM.
// The master side is the SPI slave, the slave side is spi_ram_ctrl.
interface spi_ram_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE+1:0] din;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] dout;
  logic                 tx_valid;
  logic                 addr_err;

  modport master (output din, rx_valid, input dout, tx_valid, addr_err);
  modport slave  (input din, rx_valid, output dout, tx_valid, addr_err);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Single-port RAM driven by 2-bit opcode command words from an SPI slave.
// Reads return dout/tx_valid two edges after RD_DATA and hold them for TX_HOLD cycles.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_HOLD   = 10,
  parameter int AUTO_INC  = 0
) (
  input  logic         clk,
  input  logic         rst,
  spi_ram_ctrl_if.slave bus
);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = $clog2(TX_HOLD) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_MEM, S_TX_HOLD} state_t;

  state_t               state;
  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] ram_q;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] dout;
  logic                 tx_valid;
  logic                 addr_err;
  logic [CNT_W-1:0]     cnt;

  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] payload;
  logic                 addr_ok;
  logic                 wr_cmd;
  logic                 rd_cmd;
  logic                 rd_en;

  assign opcode  = bus.din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload = bus.din[ADDR_SIZE-1:0];
  assign addr_ok = 32'(payload) < 32'(MEM_DEPTH);
  assign wr_cmd  = bus.rx_valid && !rst && (opcode == 2'b01);
  assign rd_cmd  = bus.rx_valid && (opcode == 2'b11);
  // A RD_DATA arriving while a read is already in flight is ignored.
  assign rd_en   = rd_cmd && !rst && (state != S_RD_MEM);

  assign bus.dout     = dout;
  assign bus.tx_valid = tx_valid;
  assign bus.addr_err = addr_err;

  function automatic logic [ADDR_SIZE-1:0] wrap_inc(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) >= 32'(MEM_DEPTH - 1)) return '0;
    return a + ADDR_SIZE'(1);
  endfunction

  // RAM port: write and read never share a cycle since they need different opcodes.
  always_ff @(posedge clk) begin
    if (wr_cmd) mem[wr_addr[IDX_W-1:0]] <= payload;
    if (rd_en)  ram_q <= mem[rd_addr[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dout     <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      cnt      <= '0;
    end else begin
      addr_err <= 1'b0;
      unique case (state)
        S_IDLE: if (rd_cmd) state <= S_RD_MEM;
        S_RD_MEM: begin
          dout     <= ram_q;
          tx_valid <= 1'b1;
          cnt      <= CNT_W'(TX_HOLD - 1);
          state    <= S_TX_HOLD;
          if (AUTO_INC != 0) rd_addr <= wrap_inc(rd_addr);
        end
        S_TX_HOLD: begin
          if (rd_cmd) begin
            tx_valid <= 1'b0;
            state    <= S_RD_MEM;
          end else if (cnt == '0) begin
            tx_valid <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // Placed after the FSM so an explicit RD_ADDR wins over the auto-increment.
      if (bus.rx_valid) begin
        unique case (opcode)
          2'b00: if (addr_ok) wr_addr <= payload; else addr_err <= 1'b1;
          2'b01: if (AUTO_INC != 0) wr_addr <= wrap_inc(wr_addr);
          2'b10: if (addr_ok) rd_addr <= payload; else addr_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule
